l2_req_arbiter: RTL

L2_REQ_ARBITER -- requirements
Module: l2_req_arbiter

---
 rtl/l2_req_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/l2_req_arbiter.sv
// Two-client (I-side / D-side) line-request arbiter in front of a single-outstanding L2 port.
// Requests are captured into per-side pending registers, granted round-robin, and returned on the owning side.
module l2_req_arbiter #(
  parameter int ADDR_W = 25,
  parameter int LINE_W = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_ADDR_VALID,
  input  logic [ADDR_W-1:0] I_ADDR,
  output logic [LINE_W-1:0] I_DATA,
  output logic              I_DATA_VALID,
  input  logic              D_ADDR_VALID,
  input  logic [ADDR_W-1:0] D_ADDR,
  output logic [LINE_W-1:0] D_DATA,
  output logic              D_DATA_VALID,
  output logic              L2_ADDR_VALID,
  input  logic              L2_ADDR_READY,
  output logic [ADDR_W-1:0] L2_ADDR,
  input  logic [LINE_W-1:0] L2_DATA,
  input  logic              L2_DATA_VALID,
  output logic              BUSY
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam logic SIDE_D = 1'b1;

  state_t            state_q, state_d;
  logic              pend_i_q, pend_i_d, pend_d_q, pend_d_d;
  logic [ADDR_W-1:0] addr_i_q, addr_i_d, addr_d_q, addr_d_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic              win;
  logic              l2_vld_q, l2_vld_d;
  logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
  logic [LINE_W-1:0] i_data_q, i_data_d, d_data_q, d_data_d;
  logic              i_dv_q, i_dv_d, d_dv_q, d_dv_d;

  always_comb begin
    state_d   = state_q;
    pend_i_d  = pend_i_q;
    pend_d_d  = pend_d_q;
    addr_i_d  = addr_i_q;
    addr_d_d  = addr_d_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    l2_vld_d  = l2_vld_q;
    l2_addr_d = l2_addr_q;
    i_data_d  = i_data_q;
    d_data_d  = d_data_q;
    i_dv_d    = i_dv_q;
    d_dv_d    = d_dv_q;
    // On a tie the side that did not win last time goes; otherwise the lone requester.
    win = (pend_i_q && pend_d_q) ? ~last_q : pend_d_q;
    case (state_q)
      IDLE: if (pend_i_q || pend_d_q) begin
        gnt_d     = win;
        last_d    = win;
        l2_addr_d = (win == SIDE_D) ? addr_d_q : addr_i_q;
        if (win == SIDE_D) pend_d_d = 1'b0;
        else               pend_i_d = 1'b0;
        l2_vld_d  = 1'b1;
        state_d   = REQ;
      end
      REQ: if (L2_ADDR_READY) begin
        l2_vld_d = 1'b0;
        state_d  = WAIT;
      end
      WAIT: if (L2_DATA_VALID) begin
        if (gnt_q == SIDE_D) begin
          d_data_d = L2_DATA;
          d_dv_d   = 1'b1;
        end else begin
          i_data_d = L2_DATA;
          i_dv_d   = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        i_dv_d  = 1'b0;
        d_dv_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new pulse wins over the grant-time clear so a re-request of the granted side is kept.
    if (I_ADDR_VALID) begin
      pend_i_d = 1'b1;
      addr_i_d = I_ADDR;
    end
    if (D_ADDR_VALID) begin
      pend_d_d = 1'b1;
      addr_d_d = D_ADDR;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pend_i_q  <= 1'b0;
      pend_d_q  <= 1'b0;
      addr_i_q  <= '0;
      addr_d_q  <= '0;
      gnt_q     <= 1'b0;
      last_q    <= SIDE_D;
      l2_vld_q  <= 1'b0;
      l2_addr_q <= '0;
      i_data_q  <= '0;
      d_data_q  <= '0;
      i_dv_q    <= 1'b0;
      d_dv_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_i_q  <= pend_i_d;
      pend_d_q  <= pend_d_d;
      addr_i_q  <= addr_i_d;
      addr_d_q  <= addr_d_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      l2_vld_q  <= l2_vld_d;
      l2_addr_q <= l2_addr_d;
      i_data_q  <= i_data_d;
      d_data_q  <= d_data_d;
      i_dv_q    <= i_dv_d;
      d_dv_q    <= d_dv_d;
    end
  end

  assign L2_ADDR_VALID = l2_vld_q;
  assign L2_ADDR       = l2_addr_q;
  assign I_DATA        = i_data_q;
  assign D_DATA        = d_data_q;
  assign I_DATA_VALID  = i_dv_q;
  assign D_DATA_VALID  = d_dv_q;
  assign BUSY          = (state_q != IDLE) || pend_i_q || pend_d_q;
endmodule
